scan_mux: RTL

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux_pkg.sv | 14 +
 rtl/scan_timer.sv | 32 +++
 rtl/scan_mux.sv | 86 ++++++++
 3 files changed

// File: rtl/scan_mux_pkg.sv
// Shared types for the scanning channel multiplexer: mode encoding used by
// the top level and anything that drives its mode input.
package scan_mux_pkg;

  typedef logic [1:0] mode_t;

  typedef enum mode_t {
    MODE_DIRECT   = 2'd0,
    MODE_SCAN     = 2'd1,
    MODE_PRIORITY = 2'd2,
    MODE_HOLD     = 2'd3
  } mode_e;

endpackage

// File: rtl/scan_timer.sv
// Dwell counter for SCAN mode: counts 0..SCAN_PERIOD-1 and flags the last
// cycle of each dwell with tick.
module scan_timer #(
  parameter int SCAN_PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(SCAN_PERIOD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (clear || tick) cnt_d = '0;
      else               cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scan_mux.sv
// Channel multiplexer with direct, timed-scan, priority and hold selection;
// one register stage from sel/data_in to data_out/ch_out/strobe.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int W_DATA      = 8,
  parameter int N_CH        = 4,
  parameter int SCAN_PERIOD = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [$clog2(N_CH)-1:0]   sel,
  input  logic [N_CH*W_DATA-1:0]    data_in,
  output logic [W_DATA-1:0]         data_out,
  output logic [$clog2(N_CH)-1:0]   ch_out,
  output logic                      strobe
);

  localparam int                SEL_W   = $clog2(N_CH);
  localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(N_CH - 1);

  mode_e             mode_s;
  logic              tick;
  logic [SEL_W-1:0]  ch_q, ch_d, ch_next, prio_ch;
  logic [W_DATA-1:0] data_q, data_d, next_data;
  logic              strobe_q, strobe_d;

  assign mode_s = mode_e'(mode);

  // Counter is held at zero outside SCAN so every entry gets a full dwell.
  scan_timer #(.SCAN_PERIOD(SCAN_PERIOD)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (mode_s != MODE_SCAN),
    .tick  (tick)
  );

  // Walk from the top down so the lowest nonzero channel wins.
  always_comb begin
    prio_ch = ch_q;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (data_in[k*W_DATA +: W_DATA] != '0) prio_ch = SEL_W'(k);
    end
  end

  always_comb begin
    ch_next = ch_q;
    unique case (mode_s)
      MODE_DIRECT:   ch_next = (int'(sel) > N_CH - 1) ? LAST_CH : sel;
      MODE_SCAN:     if (tick) ch_next = (ch_q == LAST_CH) ? '0 : ch_q + SEL_W'(1);
      MODE_PRIORITY: ch_next = prio_ch;
      default:       ch_next = ch_q;
    endcase
  end

  always_comb begin
    next_data = data_in[int'(ch_next)*W_DATA +: W_DATA];
    ch_d      = ch_q;
    data_d    = data_q;
    if (en && (mode_s != MODE_HOLD)) begin
      ch_d   = ch_next;
      data_d = next_data;
    end
    strobe_d = (ch_d != ch_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q     <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      ch_q     <= ch_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  assign ch_out   = ch_q;
  assign data_out = data_q;
  assign strobe   = strobe_q;

endmodule
